// File: rtl/add64_seq_pkg.sv
// Shared types and widths for the two-pass 64-bit sequential adder.
package add64_seq_pkg;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned HALF_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/add64_seq_if.sv
// Operand request / result hand-off bus of add64_seq.
interface add64_seq_if;
    import add64_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] sum;
    logic              cout;
    logic              ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/add64_seq_p_adder.sv
// 32-bit Kogge-Stone prefix adder with carry in/out.
module p_adder
    import add64_seq_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] s,
    output logic              cout
);

    localparam int unsigned LVLS = $clog2(HALF_W);

    logic [HALF_W-1:0] x;
    logic [HALF_W-1:0] g;
    logic [HALF_W-1:0] p;
    logic [HALF_W-1:0] g_n;
    logic [HALF_W-1:0] p_n;
    logic [HALF_W:0]   c;

    // Prefix tree: after LVLS levels g/p hold group generate/propagate over [i:0].
    always_comb begin
        x   = a ^ b;
        g   = a & b;
        p   = x;
        g_n = '0;
        p_n = '0;
        for (int l = 0; l < int'(LVLS); l++) begin
            g_n = g;
            p_n = p;
            for (int i = 0; i < int'(HALF_W); i++) begin
                if (i >= (1 << l)) begin
                    g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p_n[i] = p[i] & p[i - (1 << l)];
                end
            end
            g = g_n;
            p = p_n;
        end
        c    = {g | (p & {HALF_W{cin}}), cin};
        s    = x ^ c[HALF_W-1:0];
        cout = c[HALF_W];
    end

endmodule

// File: rtl/add64_seq.sv
// 64-bit add/subtract computed in two passes (low, then high half) through one 32-bit adder.
module add64_seq
    import add64_seq_pkg::*;
#(
    parameter int unsigned SUB_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    add64_seq_if.slave   bus
);

    state_t            state;
    state_t            state_nxt;
    logic              in_ready_c;
    logic              accept_c;
    logic              sub_eff;

    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic              cin_q;
    logic [HALF_W-1:0] lo_q;
    logic              c31_q;
    logic [WORD_W-1:0] sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic              hi_sel;
    logic [HALF_W-1:0] op_a;
    logic [HALF_W-1:0] op_b;
    logic              op_cin;
    logic [HALF_W-1:0] add_s;
    logic              add_co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and acceptance; DONE accepts new operands in the hand-off cycle.
    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = LO;
            end
            LO:   state_nxt = HI;
            HI:   state_nxt = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    in_ready_c = 1'b1;
                    state_nxt  = bus.in_valid ? LO : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sub_eff  = (SUB_EN != 0) ? bus.sub : 1'b0;
    assign accept_c = bus.in_valid & in_ready_c & rst_n;

    assign hi_sel = (state == HI);
    assign op_a   = hi_sel ? a_q[WORD_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign op_b   = hi_sel ? b_q[WORD_W-1:HALF_W] : b_q[HALF_W-1:0];
    assign op_cin = hi_sel ? c31_q : cin_q;

    p_adder u_p_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .s    (add_s),
        .cout (add_co)
    );

    // Operand capture on accept, low-half result in LO, final result in HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            lo_q   <= '0;
            c31_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q   <= bus.a;
                b_q   <= sub_eff ? ~bus.b : bus.b;
                cin_q <= sub_eff;
            end
            if (state == LO) begin
                lo_q  <= add_s;
                c31_q <= add_co;
            end
            if (state == HI) begin
                sum_q  <= {add_s, lo_q};
                cout_q <= add_co;
                ovf_q  <= (a_q[WORD_W-1] == b_q[WORD_W-1]) & (add_s[HALF_W-1] != a_q[WORD_W-1]);
            end
        end
    end

    assign bus.in_ready  = in_ready_c & rst_n;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_add64_seq.sv
// Scoreboard bench for add64_seq: results predicted at accept, compared at hand-off.
module tb_add64_seq;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t q[$];
    logic [65:0] last;
    logic ov_prev;

    add64_seq_if m0 ();
    add64_seq_if m1 ();

    add64_seq #(.SUB_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(m0.slave));
    add64_seq #(.SUB_EN(0)) dut_nosub (.clk(clk), .rst_n(rst_n), .bus(m1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub, input int acc);
        exp_t        e;
        logic [63:0] be;
        logic [64:0] r;
        be     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, be} + {64'd0, sub};
        e.sum  = r[63:0];
        e.cout = r[64];
        e.ovf  = (a[63] == be[63]) && (r[63] != a[63]);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: push on accept, compare while valid, check hold while not valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (m0.in_valid && m0.in_ready)
                q.push_back(model(m0.a, m0.b, m0.sub, cyc));
            if (m0.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 128'(m0.out_valid), 128'(0));
                end else begin
                    if (!ov_prev) check("latency", 128'(cyc - q[0].acc), 128'(3));
                    check("result", {m0.sum, m0.cout, m0.ovf}, {q[0].sum, q[0].cout, q[0].ovf});
                    if (m0.out_ready) begin
                        last = {q[0].sum, q[0].cout, q[0].ovf};
                        void'(q.pop_front());
                    end
                end
            end else begin
                check("hold", {m0.sum, m0.cout, m0.ovf}, last);
            end
            ov_prev = m0.out_valid;
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub);
        int n = 0;
        m0.in_valid = 1'b1;
        m0.a        = a;
        m0.b        = b;
        m0.sub      = sub;
        @(negedge clk);
        while (!m0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #1;
        m0.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || m0.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 128'(q.size()), 128'(0));
    endtask

    initial begin
        int n;
        exp_t e;
        cyc = 0; n_vec = 0; n_err = 0; last = '0; ov_prev = 1'b0;
        rst_n = 1'b0;
        m0.in_valid = 1'b0; m0.a = '0; m0.b = '0; m0.sub = 1'b0; m0.out_ready = 1'b1;
        m1.in_valid = 1'b0; m1.a = '0; m1.b = '0; m1.sub = 1'b0; m1.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(m0.in_ready), 128'(0));
        check("rst_out_valid", 128'(m0.out_valid), 128'(0));
        check("rst_result", {m0.sum, m0.cout, m0.ovf}, 128'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 128'(m0.in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Directed corners, then random traffic back-to-back.
        send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        send(64'd0, 64'd1, 1'b1);
        send(64'h8000_0000_0000_0000, 64'd1, 1'b1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        for (int i = 0; i < 24; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        drain();

        // Back-pressure with a pending request that must wait for the hand-off.
        m0.out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        n = 0;
        while (!m0.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid", 128'(m0.out_valid), 128'(1));
        m0.in_valid = 1'b1; m0.a = 64'd2; m0.b = 64'd3; m0.sub = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", 128'(m0.in_ready), 128'(0));
            check("bp_out_valid", 128'(m0.out_valid), 128'(1));
        end
        m0.out_ready = 1'b1;
        send(64'd2, 64'd3, 1'b0);
        drain();
        check("b2b_sum", 128'(m0.sum), 128'(5));

        // Reset while the high half is in flight.
        send(64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        last = '0;
        #1;
        check("midrst_out_valid", 128'(m0.out_valid), 128'(0));
        check("midrst_sum", 128'(m0.sum), 128'(0));
        check("midrst_in_ready", 128'(m0.in_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(64'd7, 64'd8, 1'b0);
        drain();
        check("post_rst_sum", 128'(m0.sum), 128'(15));

        // SUB_EN=0 instance must add even with sub asserted.
        m1.in_valid = 1'b1; m1.a = 64'd10; m1.b = 64'd3; m1.sub = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m1.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        m1.in_valid = 1'b0;
        n = 0;
        while (!m1.out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = model(64'd10, 64'd3, 1'b0, 0);
        check("nosub_valid", 128'(m1.out_valid), 128'(1));
        check("nosub_result", {m1.sum, m1.cout, m1.ovf}, {e.sum, e.cout, e.ovf});

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
